// File: rtl/ahb_axi_bdg.sv
// ---------------------------------------------------------------------------
// ahb_axi_bdg
//   AHB-Lite slave to AXI4 master bridge. Every accepted AHB transfer becomes
//   exactly one single-beat AXI transaction; only one is ever outstanding.
//   HREADY is held low from the data phase until the B/R response returns,
//   so nothing is buffered ahead of the AXI response.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   AHB slave side  (in)           hsel, htrans, haddr, hwrite, hsize, hburst,
//                                  hprot, hmasterlock, hwdata, hauser, hreadym
//                   (out)          hready, hresp, hrdata
//   AXI master side AW channel     awid..awuser, awvalid (out) / awready (in)
//                   W channel      wdata, wstrb, wlast, wvalid (out) / wready (in)
//                   B channel      bid, bresp, bvalid (in) / bready (out)
//                   AR channel     arid..aruser, arvalid (out) / arready (in)
//                   R channel      rid, rdata, rresp, rlast, rvalid (in) / rready (out)
// ---------------------------------------------------------------------------
module ahb_axi_bdg #(
   parameter int AW     = 32,
   parameter int DW     = 64,
   parameter int IDW    = 8,
   parameter int UW     = 8,
   parameter int AXI_ID = 0
) (
   input  logic              clk,
   input  logic              resetn,
   // AHB-Lite slave
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic [AW-1:0]     haddr,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [3:0]        hprot,
   input  logic              hmasterlock,
   input  logic [DW-1:0]     hwdata,
   input  logic [UW-1:0]     hauser,
   input  logic              hreadym,
   output logic              hready,
   output logic              hresp,
   output logic [DW-1:0]     hrdata,
   // AXI4 write address
   output logic [IDW-1:0]    awid,
   output logic [AW-1:0]     awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic [UW-1:0]     awuser,
   output logic              awvalid,
   input  logic              awready,
   // AXI4 write data
   output logic [DW-1:0]     wdata,
   output logic [DW/8-1:0]   wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   // AXI4 write response
   input  logic [IDW-1:0]    bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   // AXI4 read address
   output logic [IDW-1:0]    arid,
   output logic [AW-1:0]     araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic [UW-1:0]     aruser,
   output logic              arvalid,
   input  logic              arready,
   // AXI4 read data
   input  logic [IDW-1:0]    rid,
   input  logic [DW-1:0]     rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   localparam int NB = DW / 8;
   localparam int SW = $clog2(NB);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      ERR1    = 3'd5,
      ERR2    = 3'd6
   } state_t;

   state_t          state_reg, state_next, xfer_next;
   logic [AW-1:0]   addr_reg;
   logic [2:0]      size_reg;
   logic [3:0]      prot_reg;
   logic            lock_reg;
   logic [UW-1:0]   user_reg;
   logic            aw_done_reg, w_done_reg, wcap_reg;
   logic [DW-1:0]   wdata_reg;
   logic [DW-1:0]   hrdata_reg;
   logic [NB-1:0]   size_mask;
   logic            accept, b_ok, r_ok;

   // Sideband and burst information the bridge does not need: single beats
   // only, one transaction outstanding, so IDs and rlast carry nothing.
   logic unused_ok;
   assign unused_ok = ^{hburst, bid, rid, rlast};

   // Successful completions; the completion cycle is also an address phase.
   assign b_ok   = (state_reg == WR_RESP) && bvalid && !bresp[1];
   assign r_ok   = (state_reg == RD_DATA) && rvalid && !rresp[1];
   assign hready = (state_reg == IDLE) || (state_reg == ERR2) || b_ok || r_ok;
   assign hresp  = (state_reg == ERR1) || (state_reg == ERR2);
   assign accept = hsel && htrans[1] && hreadym && hready;

   // Read data is forwarded straight from R in the completion cycle so it is
   // valid while hready is high, then held until the next good read.
   assign hrdata = r_ok ? rdata : hrdata_reg;

   // ---------------- state register and datapath ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         size_reg    <= '0;
         prot_reg    <= '0;
         lock_reg    <= 1'b0;
         user_reg    <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         wcap_reg    <= 1'b0;
         wdata_reg   <= '0;
         hrdata_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg    <= haddr;
            size_reg    <= hsize;
            prot_reg    <= hprot;
            lock_reg    <= hmasterlock;
            user_reg    <= hauser;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wcap_reg    <= 1'b0;
         end
         if (state_reg == WR_REQ) begin
            if (awvalid && awready) aw_done_reg <= 1'b1;
            if (wvalid && wready)   w_done_reg  <= 1'b1;
            // hwdata is only guaranteed in the first data-phase cycle from
            // our point of view; freeze it so wdata stays stable under stall.
            if (!wcap_reg) begin
               wdata_reg <= hwdata;
               wcap_reg  <= 1'b1;
            end
         end
         if (r_ok) hrdata_reg <= rdata;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      xfer_next  = IDLE;
      state_next = state_reg;
      if (accept) begin
         if (32'(hsize) > SW) xfer_next = ERR1;      // wider than the bus
         else if (hwrite)     xfer_next = WR_REQ;
         else                 xfer_next = RD_REQ;
      end
      case (state_reg)
         IDLE:    state_next = xfer_next;
         WR_REQ:  if ((aw_done_reg || awready) && (w_done_reg || wready))
                     state_next = WR_RESP;
         WR_RESP: if (bvalid) state_next = bresp[1] ? ERR1 : xfer_next;
         RD_REQ:  if (arready) state_next = RD_DATA;
         RD_DATA: if (rvalid) state_next = rresp[1] ? ERR1 : xfer_next;
         ERR1:    state_next = ERR2;
         ERR2:    state_next = xfer_next;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- byte strobes ----------------
   // Lane mask of 2**size bytes, shifted to the address offset; misaligned
   // addresses are passed through and the shift truncates at the bus width.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_mask
         assign size_mask[gi] = (32'(gi) < (32'd1 << size_reg));
      end
   endgenerate
   assign wstrb = size_mask << addr_reg[SW-1:0];

   // ---------------- AXI outputs ----------------
   assign awvalid = (state_reg == WR_REQ) && !aw_done_reg;
   assign wvalid  = (state_reg == WR_REQ) && !w_done_reg;
   assign bready  = (state_reg == WR_RESP);
   assign arvalid = (state_reg == RD_REQ);
   assign rready  = (state_reg == RD_DATA);

   assign wdata   = wcap_reg ? wdata_reg : hwdata;
   assign wlast   = 1'b1;

   assign awid    = IDW'(AXI_ID);
   assign awaddr  = addr_reg;
   assign awlen   = 8'd0;
   assign awsize  = size_reg;
   assign awburst = 2'b01;
   assign awlock  = lock_reg;
   assign awcache = {2'b00, prot_reg[3], prot_reg[2]};
   assign awprot  = {~prot_reg[0], 1'b0, prot_reg[1]};
   assign awuser  = user_reg;

   assign arid    = IDW'(AXI_ID);
   assign araddr  = addr_reg;
   assign arlen   = 8'd0;
   assign arsize  = size_reg;
   assign arburst = 2'b01;
   assign arlock  = lock_reg;
   assign arcache = {2'b00, prot_reg[3], prot_reg[2]};
   assign arprot  = {~prot_reg[0], 1'b0, prot_reg[1]};
   assign aruser  = user_reg;

endmodule
